// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the datapath and a byte-addressed RAM; double-words are split into two word accesses.
// Optional MOC wait timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int unsigned ADDR_MAX       = 511,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        ReadWrite,
    input  logic [1:0]  Size,
    input  logic        SignedUnsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WrDataHi,
    input  logic [31:0] WrDataLo,
    output logic [31:0] RdDataHi,
    output logic [31:0] RdDataLo,
    output logic        Busy,
    output logic        Done,
    output logic [1:0]  ErrCode,
    output logic        MOV,
    output logic        MemRW,
    output logic [1:0]  MemSize,
    output logic        MemSigned,
    output logic [31:0] MemAddr,
    output logic [31:0] MemDataIn,
    input  logic [31:0] MemDataOut,
    input  logic        MOC
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DWORD  = 2'b11;

`ifdef MEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_t;

    state_t            state;
    logic              rw_q;
    logic              is_dword_q;
    logic              second_q;
    logic [31:0]       addr_q;
    logic [31:0]       wr_lo_q;
    logic [31:0]       rd_hi_tmp;
    logic [CNT_W-1:0]  cnt;

    logic              misaligned_c;
    logic              out_of_range_c;
    logic [3:0]        nbytes_c;
    logic [32:0]       last_addr_c;
    logic              timeout_hit_c;

    // Request qualification: alignment first, then range of the last byte touched
    always_comb begin
        misaligned_c = 1'b0;
        nbytes_c     = 4'd1;
        case (Size)
            2'b00: begin misaligned_c = 1'b0;         nbytes_c = 4'd1; end
            2'b01: begin misaligned_c = Addr[0];      nbytes_c = 4'd2; end
            2'b10: begin misaligned_c = |Addr[1:0];   nbytes_c = 4'd4; end
            default: begin misaligned_c = |Addr[2:0]; nbytes_c = 4'd8; end
        endcase
        last_addr_c    = 33'(Addr) + 33'(nbytes_c) - 33'd1;
        out_of_range_c = last_addr_c > 33'(ADDR_MAX);
    end

    assign timeout_hit_c = TIMEOUT_EN && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            rw_q       <= 1'b0;
            is_dword_q <= 1'b0;
            second_q   <= 1'b0;
            addr_q     <= '0;
            wr_lo_q    <= '0;
            rd_hi_tmp  <= '0;
            cnt        <= '0;
            RdDataHi   <= '0;
            RdDataLo   <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            ErrCode    <= ERR_OK;
            MOV        <= 1'b0;
            MemRW      <= 1'b0;
            MemSize    <= 2'b00;
            MemSigned  <= 1'b0;
            MemAddr    <= '0;
            MemDataIn  <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req) begin
                        rw_q       <= ReadWrite;
                        is_dword_q <= (Size == SZ_DWORD);
                        addr_q     <= Addr;
                        wr_lo_q    <= WrDataLo;
                        second_q   <= 1'b0;
                        cnt        <= '0;
                        Busy       <= 1'b1;
                        if (misaligned_c) begin
                            state   <= DONE;
                            Done    <= 1'b1;
                            ErrCode <= ERR_ALIGN;
                        end else if (out_of_range_c) begin
                            state   <= DONE;
                            Done    <= 1'b1;
                            ErrCode <= ERR_RANGE;
                        end else begin
                            state     <= ACCESS;
                            MOV       <= 1'b1;
                            MemRW     <= ReadWrite;
                            MemSize   <= (Size == SZ_DWORD) ? SZ_WORD : Size;
                            MemSigned <= SignedUnsigned;
                            MemAddr   <= Addr;
                            MemDataIn <= (Size == SZ_DWORD) ? WrDataHi : WrDataLo;
                        end
                    end
                end
                ACCESS: begin
                    if (MOC) begin
                        MOV <= 1'b0;
                        if (is_dword_q && !second_q) begin
                            // Hold the MS word until the whole double-word succeeds
                            if (rw_q) rd_hi_tmp <= MemDataOut;
                            state <= GAP;
                        end else begin
                            if (rw_q) begin
                                RdDataHi <= is_dword_q ? rd_hi_tmp : 32'h0;
                                RdDataLo <= MemDataOut;
                            end
                            state   <= DONE;
                            Done    <= 1'b1;
                            ErrCode <= ERR_OK;
                        end
                    end else if (timeout_hit_c) begin
                        MOV     <= 1'b0;
                        state   <= DONE;
                        Done    <= 1'b1;
                        ErrCode <= ERR_TMO;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    state     <= ACCESS;
                    MOV       <= 1'b1;
                    second_q  <= 1'b1;
                    cnt       <= '0;
                    MemAddr   <= addr_q + 32'd4;
                    MemDataIn <= wr_lo_q;
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
